// File: rtl/floor_request_scheduler.sv
// Purpose: single-car scheduler; picks direction, times travel/door dwell, pulses clears for served floor requests.
// Latency: one floor per MOVE_CYCLES + 1 check cycle; door opens the cycle after a stop decision.
// Backpressure: none; clear pulses are fire-and-forget, held buttons are not retried. Option macro: SCHED_DOOR_REOPEN_EN.
module floor_request_scheduler #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int MOVE_CYCLES   = 16,
    parameter int DOOR_CYCLES   = 32,
    localparam int FLOOR_W      = $clog2(BUTTONS_WIDTH)
) (
    input  logic                      clk,
    input  logic                      a_reset,
    input  logic [BUTTONS_WIDTH-1:0]  active_in_levels,
    input  logic [BUTTONS_WIDTH-2:0]  active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1]  active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0]  inactivate_in_levels,
    output logic [BUTTONS_WIDTH-2:0]  inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1]  inactivate_out_down_levels,
    output logic [FLOOR_W-1:0]        current_floor,
    output logic                      dir_up,
    output logic                      moving,
    output logic                      door_open
);

    localparam int TMR_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0]         MOVE_LAST = TMR_W'(MOVE_CYCLES - 1);
    localparam logic [TMR_W-1:0]         DOOR_LAST = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]       TOP_FLOOR = FLOOR_W'(BUTTONS_WIDTH - 1);
    localparam logic [BUTTONS_WIDTH-1:0] ONE_B     = {{(BUTTONS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_CHECK = 2'd2,
        S_DOOR  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [FLOOR_W-1:0]         current_floor_q, current_floor_d;
    logic                       dir_up_q, dir_up_d;
    logic                       moving_q, moving_d;
    logic                       door_open_q, door_open_d;
    logic [BUTTONS_WIDTH-1:0]   inact_in_q, inact_in_d;
    logic [BUTTONS_WIDTH-2:0]   inact_up_q, inact_up_d;
    logic [BUTTONS_WIDTH-1:1]   inact_dn_q, inact_dn_d;

    logic [BUTTONS_WIDTH-1:0]   floor_oh, above_mask, below_mask, all_req;
    logic                       in_here, up_here, dn_here, any_here;
    logic                       req_above, req_below, req_fwd, req_back;
    logic                       fwd_here, opp_here, serve_opp, serve_dir;
    logic [BUTTONS_WIDTH-1:0]   srv_in;
    logic [BUTTONS_WIDTH-2:0]   srv_up;
    logic [BUTTONS_WIDTH-1:1]   srv_dn;
`ifdef SCHED_DOOR_REOPEN_EN
    logic                       reopen_in, reopen_fwd;
`endif

    // Request decode relative to the car position and committed direction.
    always_comb begin
        floor_oh   = ONE_B << current_floor_q;
        // Top floor: shifted one-hot is zero, so the above-mask collapses to zero.
        above_mask = ~((floor_oh << 1) - ONE_B);
        below_mask = floor_oh - ONE_B;
        all_req    = active_in_levels
                   | {1'b0, active_out_up_levels}
                   | {active_out_down_levels, 1'b0};

        in_here    = |(active_in_levels & floor_oh);
        up_here    = |(active_out_up_levels & floor_oh[BUTTONS_WIDTH-2:0]);
        dn_here    = |(active_out_down_levels & floor_oh[BUTTONS_WIDTH-1:1]);
        any_here   = in_here | up_here | dn_here;

        req_above  = |(all_req & above_mask);
        req_below  = |(all_req & below_mask);
        req_fwd    = dir_up_q ? req_above : req_below;
        req_back   = dir_up_q ? req_below : req_above;

        fwd_here   = dir_up_q ? up_here : dn_here;
        opp_here   = dir_up_q ? dn_here : up_here;
        // The opposite hall call is only taken when the car has nothing left ahead.
        serve_opp  = opp_here & ~req_fwd;

        serve_dir = dir_up_q;
        if (serve_opp) begin
            serve_dir = ~dir_up_q;
        end
        if (current_floor_q == '0) begin
            serve_dir = 1'b1;
        end
        if (current_floor_q == TOP_FLOOR) begin
            serve_dir = 1'b0;
        end

        srv_in = in_here ? floor_oh : '0;
        srv_up = ((dir_up_q & fwd_here) | (~dir_up_q & serve_opp)) ? floor_oh[BUTTONS_WIDTH-2:0] : '0;
        srv_dn = ((~dir_up_q & fwd_here) | (dir_up_q & serve_opp)) ? floor_oh[BUTTONS_WIDTH-1:1] : '0;

`ifdef SCHED_DOOR_REOPEN_EN
        // Skip bits pulsed last cycle: their latch has not cleared yet.
        reopen_in  = in_here & ~(|inact_in_q);
        reopen_fwd = fwd_here & ~(dir_up_q ? (|inact_up_q) : (|inact_dn_q));
`endif
    end

    // Next-state, timer, position, direction and clear-pulse generation.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        current_floor_d = current_floor_q;
        dir_up_d        = dir_up_q;
        inact_in_d      = '0;
        inact_up_d      = '0;
        inact_dn_d      = '0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (any_here) begin
                    state_d    = S_DOOR;
                    inact_in_d = srv_in;
                    inact_up_d = srv_up;
                    inact_dn_d = srv_dn;
                    dir_up_d   = serve_dir;
                end else if (req_fwd) begin
                    state_d = S_MOVE;
                end else if (req_back) begin
                    dir_up_d = ~dir_up_q;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (timer_q == MOVE_LAST) begin
                    timer_d         = '0;
                    current_floor_d = dir_up_q ? (current_floor_q + FLOOR_W'(1))
                                               : (current_floor_q - FLOOR_W'(1));
                    state_d         = S_CHECK;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CHECK: begin
                timer_d = '0;
                if (in_here || fwd_here || !req_fwd) begin
                    if (any_here) begin
                        state_d    = S_DOOR;
                        inact_in_d = srv_in;
                        inact_up_d = srv_up;
                        inact_dn_d = srv_dn;
                        dir_up_d   = serve_dir;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_DOOR: begin
`ifdef SCHED_DOOR_REOPEN_EN
                if (reopen_in || reopen_fwd) begin
                    timer_d    = '0;
                    inact_in_d = reopen_in ? floor_oh : '0;
                    if (dir_up_q) begin
                        inact_up_d = reopen_fwd ? floor_oh[BUTTONS_WIDTH-2:0] : '0;
                    end else begin
                        inact_dn_d = reopen_fwd ? floor_oh[BUTTONS_WIDTH-1:1] : '0;
                    end
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`else
                if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        moving_d    = (state_d == S_MOVE);
        door_open_d = (state_d == S_DOOR);
    end

    // State and registered outputs; reset returns the car to floor 0 heading up.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            current_floor_q <= '0;
            dir_up_q        <= 1'b1;
            moving_q        <= 1'b0;
            door_open_q     <= 1'b0;
            inact_in_q      <= '0;
            inact_up_q      <= '0;
            inact_dn_q      <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            current_floor_q <= current_floor_d;
            dir_up_q        <= dir_up_d;
            moving_q        <= moving_d;
            door_open_q     <= door_open_d;
            inact_in_q      <= inact_in_d;
            inact_up_q      <= inact_up_d;
            inact_dn_q      <= inact_dn_d;
        end
    end

    assign inactivate_in_levels       = inact_in_q;
    assign inactivate_out_up_levels   = inact_up_q;
    assign inactivate_out_down_levels = inact_dn_q;
    assign current_floor              = current_floor_q;
    assign dir_up                     = dir_up_q;
    assign moving                     = moving_q;
    assign door_open                  = door_open_q;

endmodule
